// File: rtl/jogo_sequencia_param.sv
// Purpose: parametrised sequence-memory game core; draws notes, shows the growing sequence, checks the player's presses.
// Latency: jogar edge to PREPARA 1 cycle, PREPARA to first shown note 2 cycles; outputs are registered or decoded from registered state.
// Backpressure: none; buttons are level inputs, presses outside ESPERA/SOLTA and jogar edges outside INICIAL/FIM states are ignored.
module jogo_sequencia_param #(
    parameter int N_NOTAS        = 7,
    parameter int MAX_RODADAS    = 16,
    parameter int NOTA_CICLOS    = 500,
    parameter int PAUSA_CICLOS   = 250,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int NW = $clog2(N_NOTAS + 1),
    localparam int PW = $clog2(MAX_RODADAS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               jogar,
    input  logic               treinamento,
    input  logic [N_NOTAS-1:0] botoes,
    output logic [N_NOTAS-1:0] leds,
    output logic [NW-1:0]      nota,
    output logic [PW-1:0]      pontos,
    output logic               acertou,
    output logic               errou,
    output logic               pronto,
    output logic [4:0]         db_estado
);
    localparam int AW     = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
    localparam int MAX_T1 = (NOTA_CICLOS > PAUSA_CICLOS) ? NOTA_CICLOS : PAUSA_CICLOS;
    localparam int MAX_T  = (MAX_T1 > TIMEOUT_CICLOS) ? MAX_T1 : TIMEOUT_CICLOS;
    localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    typedef enum logic [4:0] {
        INICIAL    = 5'd0,
        PREPARA    = 5'd1,
        SORTEIA    = 5'd2,
        MOSTRA     = 5'd3,
        INTERVALO  = 5'd4,
        ESPERA     = 5'd5,
        COMPARA    = 5'd6,
        SOLTA      = 5'd7,
        PROXIMA    = 5'd8,
        ERRO       = 5'd9,
        FIM_ACERTO = 5'd10,
        FIM_ERRO   = 5'd11
    } estado_t;

    estado_t            estado;
    estado_t            estado_prox;
    logic               jogar_d;
    logic               pulso;
    logic [NW-1:0]      cnt;
    logic [NW-1:0]      mem [MAX_RODADAS];
    logic [PW-1:0]      comprimento;
    logic [PW-1:0]      idx;
    logic [TW-1:0]      timer;
    logic [N_NOTAS-1:0] jogada;
    logic               modo;
    logic [NW-1:0]      nota_mem;
    logic               ultimo;
    logic               correto;

    // Note index (1..N_NOTAS) to one-hot LED pattern; 0 gives all-off.
    function automatic logic [N_NOTAS-1:0] dec(input logic [NW-1:0] n);
        logic [N_NOTAS-1:0] d;
        d = '0;
        for (int i = 0; i < N_NOTAS; i++) d[i] = (n == NW'(i + 1));
        return d;
    endfunction

    // One-hot press back to its note index.
    function automatic logic [NW-1:0] enc(input logic [N_NOTAS-1:0] b);
        logic [NW-1:0] e;
        e = '0;
        for (int i = 0; i < N_NOTAS; i++) if (b[i]) e = NW'(i + 1);
        return e;
    endfunction

    assign pulso     = jogar & ~jogar_d;
    assign nota_mem  = mem[idx[AW-1:0]];
    assign ultimo    = (idx == comprimento - PW'(1));
    // The stored note decodes to exactly one bit, so equality also rules out multi-press.
    assign correto   = (jogada != '0) && (jogada == dec(nota_mem));
    assign db_estado = estado;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= estado_prox;
    end

    // Next-state logic and decoded LED/note outputs.
    always_comb begin
        estado_prox = estado;
        leds        = '0;
        nota        = '0;
        case (estado)
            INICIAL:    if (pulso) estado_prox = PREPARA;
            PREPARA:    estado_prox = SORTEIA;
            SORTEIA:    estado_prox = MOSTRA;
            MOSTRA: begin
                leds = dec(nota_mem);
                nota = nota_mem;
                if (timer == TW'(NOTA_CICLOS - 1)) estado_prox = INTERVALO;
            end
            INTERVALO:  if (timer == TW'(PAUSA_CICLOS - 1)) estado_prox = ultimo ? ESPERA : MOSTRA;
            ESPERA: begin
                if (botoes != '0)                           estado_prox = COMPARA;
                else if (timer == TW'(TIMEOUT_CICLOS - 1))  estado_prox = ERRO;
            end
            COMPARA:    estado_prox = correto ? SOLTA : ERRO;
            SOLTA: begin
                leds = jogada;
                nota = enc(jogada);
                if (botoes == '0) estado_prox = ultimo ? PROXIMA : ESPERA;
            end
            PROXIMA:    estado_prox = (comprimento == PW'(MAX_RODADAS)) ? FIM_ACERTO : SORTEIA;
            ERRO:       estado_prox = modo ? MOSTRA : FIM_ERRO;
            FIM_ACERTO: if (pulso) estado_prox = PREPARA;
            FIM_ERRO:   if (pulso) estado_prox = PREPARA;
            default:    estado_prox = INICIAL;
        endcase
    end

    // Sequence memory: a new note is drawn from the free-running counter.
    always_ff @(posedge clock) begin
        if (estado == SORTEIA) mem[comprimento[AW-1:0]] <= cnt + NW'(1);
    end

    // Datapath: edge detector, note generator, pointers, timer, score and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            jogar_d     <= 1'b0;
            cnt         <= '0;
            timer       <= '0;
            comprimento <= '0;
            idx         <= '0;
            jogada      <= '0;
            modo        <= 1'b0;
            pontos      <= '0;
            acertou     <= 1'b0;
            errou       <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            jogar_d <= jogar;
            cnt     <= (cnt == NW'(N_NOTAS - 1)) ? '0 : cnt + NW'(1);
            timer   <= (estado_prox != estado) ? '0 : timer + TW'(1);

            case (estado)
                PREPARA: begin
                    comprimento <= '0;
                    idx         <= '0;
                    pontos      <= '0;
                    modo        <= treinamento;
                end
                SORTEIA: begin
                    comprimento <= comprimento + PW'(1);
                    idx         <= '0;
                end
                INTERVALO: if (timer == TW'(PAUSA_CICLOS - 1)) idx <= ultimo ? '0 : idx + PW'(1);
                ESPERA:    if (botoes != '0) jogada <= botoes;
                SOLTA:     if (botoes == '0 && !ultimo) idx <= idx + PW'(1);
                PROXIMA:   if (pontos < PW'(MAX_RODADAS)) pontos <= pontos + PW'(1);
                ERRO:      if (modo) idx <= '0;
                default:   ;
            endcase

            // Flags clear on the way into PREPARA; the training error flag lives only during ERRO.
            if (estado_prox == PREPARA) begin
                acertou <= 1'b0;
                errou   <= 1'b0;
                pronto  <= 1'b0;
            end else if (estado_prox == FIM_ACERTO) begin
                acertou <= 1'b1;
                pronto  <= 1'b1;
            end else if (estado_prox == FIM_ERRO) begin
                errou  <= 1'b1;
                pronto <= 1'b1;
            end else if (estado_prox == ERRO && modo) begin
                errou <= 1'b1;
            end else if (estado == ERRO) begin
                errou <= 1'b0;
            end
        end
    end
endmodule

// File: doc/jogo_sequencia_param.md
# jogo_sequencia_param

Parametrised sequence-memory game core for the Sinfonia do Espectro family. It is the successor to the fixed 7-button game datapath/control pair, with a configurable note count, maximum round count and show, pause and timeout durations. It adds a free-running note generator, a training mode that replays a round after an error, play timeout and multi-press detection. It sits between the button and LED board I/O and the score display and Arduino note interface.

## Interface
Parameters:
- N_NOTAS, 7: number of buttons, LEDs and distinct notes (2..15).
- MAX_RODADAS, 16: rounds needed to win, equal to the sequence memory depth (1..64).
- NOTA_CICLOS, 500: cycles each note is shown.
- PAUSA_CICLOS, 250: silent cycles after each shown note.
- TIMEOUT_CICLOS, 5000: cycles allowed per play before timeout.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- jogar  in  1  start level; rising edge detected internally.
- treinamento  in  1  mode select (1 = training); sampled in PREPARA.
- botoes  in  N_NOTAS  raw button levels, already synchronised externally.
- leds  out  N_NOTAS  one-hot shown or pressed note.
- nota  out  clog2(N_NOTAS+1)  note index 1..N_NOTAS, 0 = silence (to Arduino).
- pontos  out  clog2(MAX_RODADAS+1)  completed rounds.
- acertou  out  1  win flag.
- errou  out  1  loss flag (normal mode) / 1-cycle error pulse (training mode).
- pronto  out  1  game finished.
- db_estado  out  5  state code.

## Operation
- Edge detector: register jogar_d, cleared to 0 by reset. pulso = jogar & ~jogar_d. jogar held high across reset release yields one pulse.
- Note generator: counter cnt runs 0..N_NOTAS-1 every cycle, wraps, and resets to 0. A new note is stored as cnt+1.
- Memory: MAX_RODADAS entries of clog2(N_NOTAS+1) bits. comprimento is the current sequence length; idx is the show/play pointer.
- States and db_estado codes:
  - INICIAL (0): on pulso, go to PREPARA.
  - PREPARA (1): comprimento=0, pontos=0, flags cleared, mode latched; go to SORTEIA.
  - SORTEIA (2): mem[comprimento]=cnt+1, comprimento++, idx=0; go to MOSTRA.
  - MOSTRA (3): show mem[idx] for NOTA_CICLOS cycles; go to INTERVALO.
  - INTERVALO (4): silence for PAUSA_CICLOS cycles. If idx==comprimento-1, set idx=0 and go to ESPERA; else idx++ and go to MOSTRA.
  - ESPERA (5): timer counts. Any nonzero botoes goes to COMPARA. Timer reaching TIMEOUT_CICLOS-1 goes to ERRO.
  - COMPARA (6): botoes is registered. It is correct if one-hot and equal to mem[idx]; go to SOLTA. Otherwise go to ERRO.
  - SOLTA (7): wait for botoes==0. Then, if idx==comprimento-1, go to PROXIMA; else idx++, timer cleared, go to ESPERA.
  - PROXIMA (8): pontos++. If comprimento==MAX_RODADAS, go to FIM_ACERTO; else go to SORTEIA.
  - ERRO (9): in training, errou=1 for this cycle, idx=0, go to MOSTRA (same sequence, pontos kept). In normal mode, go to FIM_ERRO.
  - FIM_ACERTO (10), FIM_ERRO (11): flags held; pulso goes to PREPARA.
- Outputs:
  - leds = onehot(mem[idx]) in MOSTRA and onehot(registered press) in SOLTA; 0 otherwise.
  - nota is the matching index, or 0.
- Two or more buttons pressed at once in ESPERA count as a wrong play.
- pulso outside INICIAL and the FIM states is ignored.
- Widths:
  - All duration counters are sized clog2(max parameter) and cleared on every state entry.
  - pontos never exceeds MAX_RODADAS.

## Timing
- Reset (synchronous): state=INICIAL; leds=0, nota=0, pontos=0, acertou=0, errou=0, pronto=0, db_estado=0; cnt=0, jogar_d=0; memory contents are don't-care.
- All outputs are registered or decoded from registered state. There is no combinational path from botoes or jogar to any output.
- Latency:
  - jogar rising edge to PREPARA: 1 cycle.
  - PREPARA to first MOSTRA: 2 cycles.
  - Each note is exactly NOTA_CICLOS cycles of leds≠0, followed by exactly PAUSA_CICLOS cycles of silence.
- acertou and pronto rise on entry to FIM_ACERTO. errou and pronto rise on entry to FIM_ERRO. All three fall in the PREPARA cycle.
- A press is sampled one cycle after it appears in ESPERA. Presses during MOSTRA or INTERVALO are ignored.
- Reset takes priority over every transition, including mid-MOSTRA and mid-SOLTA.

## Test plan
Bench parameters: N_NOTAS=4, MAX_RODADAS=2, NOTA_CICLOS=4, PAUSA_CICLOS=2, TIMEOUT_CICLOS=20.
- Reset check: hold reset 3 cycles -> db_estado=0, leds=0, nota=0, pontos=0, acertou=errou=pronto=0.
- Full win, normal mode: pulse jogar. Round 1 shows 1 note for exactly 4 cycles; press the matching button and release. pontos=1, then round 2 shows 2 notes with the first unchanged. Repeat both -> acertou=1, pronto=1, pontos=2, db_estado=10, all held for 50 cycles until jogar.
- Wrong button, normal mode: in round 1 press a non-matching button -> errou=1, pronto=1, pontos=0, db_estado=11. A new jogar pulse clears the flags and restarts.
- Training replay: treinamento=1, wrong press -> errou high for exactly 1 cycle, the same note is shown again, pontos unchanged. The correct press then gives pontos=1.
- Timeout and multi-press: no press for 20 cycles in ESPERA -> FIM_ERRO. Separately, pressing botoes=4'b0011 -> FIM_ERRO.
- Reset mid-game: assert reset during MOSTRA -> next cycle db_estado=0 and leds=0. jogar held high through reset release -> exactly one game start.
